// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: register addresses, the bit
// layout of the UART_CON register, and the state type used by both the
// transmit and the receive state machines.
package uart_pkg;

    // Word register addresses, matched against the full 32-bit bus address.
    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    // UART_CON bit positions.
    localparam int CON_TX_IRQ_EN = 0;
    localparam int CON_RX_IRQ_EN = 1;
    localparam int CON_TX_BUSY   = 2;
    localparam int CON_RX_VALID  = 3;
    localparam int CON_TX_DONE   = 4;
    localparam int CON_RX_OVR    = 5;
    localparam int CON_RX_FERR   = 6;

    // Frame phase, shared by the TX and RX state machines.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer on the raw line, falling-edge start
// detection, mid-bit sampling of start, 8 data bits (LSB first) and stop.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   rx          - asynchronous serial input, idle high
//   data        - last correctly framed byte (valid when done pulses)
//   done        - one-cycle pulse: byte received with stop bit = 1
//   frame_err   - one-cycle pulse: byte discarded because stop bit = 0
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       done,
    output logic       frame_err
);

    localparam logic [15:0] DIV_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

    logic [1:0]  sync;
    logic        rx_s;
    logic        rx_prev;
    uart_state_t state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;

    assign rx_s = sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync      <= 2'b11;
            rx_prev   <= 1'b1;
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync      <= {sync[0], rx};
            rx_prev   <= rx_s;
            done      <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                // Only a high-to-low transition starts a frame, so after a
                // bad stop bit the line must return high before re-arming.
                ST_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_s) begin
                        state <= ST_START;
                    end
                end
                // Half a bit in: still low means a real start bit,
                // high means a glitch and the frame is dropped silently.
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt == DIV_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (cnt == DIV_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        if (rx_s) begin
                            data <= shift;
                            done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped UART peripheral: register decode (TXD, RXD, CON), the
// transmit state machine, status/sticky flags and the interrupt request.
// The receiver lives in uart_rx.
// Ports:
//   clk, reset         - system clock, synchronous active-high reset
//   MemRd, MemWr       - CPU bus read / write strobes
//   Addr, WriteData    - CPU byte address and store data
//   ReadData           - combinational load data (0 when not selected)
//   rx                 - asynchronous serial input
//   tx                 - registered serial output, idle high
//   irq                - registered level interrupt request
module uart_periph
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);

    localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);

    logic        wr_txd, wr_con, rd_rxd, rd_con;
    logic        tx_irq_en, rx_irq_en, tx_done, rx_valid, rx_overrun, rx_frame_err;
    logic        tx_busy, tx_end;
    logic [7:0]  rxd;
    logic [31:0] con_word;
    logic        wdata_unused;

    uart_state_t tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;

    logic [7:0]  rx_data;
    logic        rx_done, rx_ferr;

    uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (rx_data),
        .done      (rx_done),
        .frame_err (rx_ferr)
    );

    assign wr_txd = MemWr && (Addr == ADDR_TXD);
    assign wr_con = MemWr && (Addr == ADDR_CON);
    assign rd_rxd = MemRd && (Addr == ADDR_RXD);
    assign rd_con = MemRd && (Addr == ADDR_CON);

    assign tx_busy = (tx_state != ST_IDLE);
    assign tx_end  = (tx_state == ST_STOP) && (tx_cnt == DIV_LAST);

    // Only the low byte of store data is meaningful to this block.
    assign wdata_unused = ^WriteData[31:8];

    always_comb begin
        con_word                = '0;
        con_word[CON_TX_IRQ_EN] = tx_irq_en;
        con_word[CON_RX_IRQ_EN] = rx_irq_en;
        con_word[CON_TX_BUSY]   = tx_busy;
        con_word[CON_RX_VALID]  = rx_valid;
        con_word[CON_TX_DONE]   = tx_done;
        con_word[CON_RX_OVR]    = rx_overrun;
        con_word[CON_RX_FERR]   = rx_frame_err;
    end

    always_comb begin
        ReadData = '0;
        if (rd_rxd) begin
            ReadData = {24'h0, rxd};
        end else if (rd_con) begin
            ReadData = con_word;
        end
    end

    // Transmitter: tx is loaded together with the state so the line
    // changes on the same edge the FSM enters each bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (wr_txd) begin
                        tx_shift <= WriteData[7:0];
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx       <= 1'b0;
                        tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt   <= '0;
                        tx       <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_state <= ST_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx       <= 1'b1;
                            tx_state <= ST_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx       <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= ST_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    // Status flags: a set event always takes priority over a clearing read
    // on the same edge, so no event is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_irq_en    <= 1'b0;
            rx_irq_en    <= 1'b0;
            tx_done      <= 1'b0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            rxd          <= '0;
            irq          <= 1'b0;
        end else begin
            if (wr_con) begin
                tx_irq_en <= WriteData[CON_TX_IRQ_EN];
                rx_irq_en <= WriteData[CON_RX_IRQ_EN];
            end

            if (rx_done) begin
                rxd      <= rx_data;
                rx_valid <= 1'b1;
            end else if (rd_rxd) begin
                rx_valid <= 1'b0;
            end

            if (rx_done && rx_valid) begin
                rx_overrun <= 1'b1;
            end else if (rd_con) begin
                rx_overrun <= 1'b0;
            end

            if (rx_ferr) begin
                rx_frame_err <= 1'b1;
            end else if (rd_con) begin
                rx_frame_err <= 1'b0;
            end

            if (tx_end) begin
                tx_done <= 1'b1;
            end else if (rd_con) begin
                tx_done <= 1'b0;
            end

            irq <= (tx_irq_en && tx_done) || (rx_irq_en && rx_valid);
        end
    end

endmodule

// File: tb/tb_uart_periph.sv
// Self-checking bench for uart_periph with BAUD_DIV = 16. A behavioural
// model of the register file (expected RXD, flags, enables) is updated from
// the frames and bus accesses the bench issues; serial frames are built
// from the byte value with plain bit arithmetic.
module tb_uart_periph;

    localparam int DIV = 16;
    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;

    logic        clk;
    logic        reset;
    logic        MemRd, MemWr;
    logic [31:0] Addr, WriteData, ReadData;
    logic        rx, tx, irq;

    int vectors;
    int miscompares;

    // Reference model state
    logic       m_txen, m_rxen, m_valid, m_ovr, m_ferr, m_txdone;
    logic [7:0] m_rxd;

    uart_periph #(.BAUD_DIV(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRd     (MemRd),
        .MemWr     (MemWr),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .rx        (rx),
        .tx        (tx),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] con_exp(input logic busy);
        return {25'h0, m_ferr, m_ovr, m_txdone, m_valid, busy, m_rxen, m_txen};
    endfunction

    function automatic logic exp_irq();
        return (m_txen & m_txdone) | (m_rxen & m_valid);
    endfunction

    task automatic model_clear();
        m_txen = 0; m_rxen = 0; m_valid = 0; m_ovr = 0; m_ferr = 0; m_txdone = 0;
        m_rxd = '0;
    endtask

    // All bus tasks start and end just after a falling edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        MemWr = 1'b1; Addr = a; WriteData = d;
        tick(1);
        MemWr = 1'b0; Addr = '0; WriteData = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        MemRd = 1'b1; Addr = a;
        #1 d = ReadData;
        tick(1);
        MemRd = 1'b0; Addr = '0;
    endtask

    task automatic rd_con_chk(input string tag, input logic busy);
        logic [31:0] d;
        bus_read(A_CON, d);
        chk(tag, d, con_exp(busy));
        m_txdone = 0; m_ovr = 0; m_ferr = 0;
    endtask

    task automatic rd_rxd_chk(input string tag);
        logic [31:0] d;
        bus_read(A_RXD, d);
        chk(tag, d, {24'h0, m_rxd});
        m_valid = 0;
    endtask

    task automatic con_write(input logic [31:0] d);
        bus_write(A_CON, d);
        m_txen = d[0];
        m_rxen = d[1];
    endtask

    // Drive one serial frame on rx; stop selects the stop-bit level.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx = fr[k];
            tick(DIV);
        end
        rx = 1'b1;
        tick(8);
        if (stop) begin
            if (m_valid) m_ovr = 1;
            m_rxd   = b;
            m_valid = 1;
        end else begin
            m_ferr = 1;
        end
    endtask

    task automatic glitch_rx();
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(24);
    endtask

    // Send one byte and check every bit at mid-bit; optionally write a
    // different byte to TXD while the frame is in flight.
    task automatic tx_frame(input logic [7:0] b, input logic poke);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        bus_write(A_TXD, {24'h0, b});
        tick(DIV / 2);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("tx_bit%0d_%02h", k, b), {31'h0, tx}, {31'h0, fr[k]});
            if (k < 9) begin
                if (poke && k == 3) begin
                    bus_write(A_TXD, {24'h0, ~b});
                    tick(DIV - 1);
                end else begin
                    tick(DIV);
                end
            end
        end
        // Now 152 cycles after the write edge: read CON at 159 and at 160.
        tick(7);
        rd_con_chk("tx_con_c159", 1'b1);
        m_txdone = 1;
        rd_con_chk("tx_con_c160", 1'b0);
        tick(2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        logic [9:0]  fr;
        int          kind;

        vectors = 0; miscompares = 0;
        reset = 1'b1; MemRd = 0; MemWr = 0; Addr = '0; WriteData = '0; rx = 1'b1;
        model_clear();
        tick(3);
        reset = 1'b0;

        // Reset state
        chk("rst_tx", {31'h0, tx}, 32'h1);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rd_con_chk("rst_con", 1'b0);
        rd_rxd_chk("rst_rxd");
        bus_read(A_TXD, d);
        chk("rd_txd_zero", d, 32'h0);
        bus_read(32'h4000_0024, d);
        chk("rd_unmapped", d, 32'h0);

        // Fixed TX frame 0xA5
        tx_frame(8'hA5, 1'b0);

        // Single RX byte
        send_rx(8'h3C, 1'b1);
        rd_con_chk("rx3c_con", 1'b0);
        rd_rxd_chk("rx3c_rxd");
        rd_con_chk("rx3c_con_after", 1'b0);

        // Overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        Addr = A_CON;
        #1 chk("no_rd_strobe", ReadData, 32'h0);
        tick(1);
        Addr = '0;
        rd_con_chk("ovr_con", 1'b0);
        rd_rxd_chk("ovr_rxd");
        rd_con_chk("ovr_cleared", 1'b0);

        // Glitch and framing error
        glitch_rx();
        rd_con_chk("glitch_con", 1'b0);
        send_rx($urandom_range(0, 255), 1'b0);
        tick(DIV);
        rd_con_chk("ferr_con", 1'b0);
        rd_con_chk("ferr_cleared", 1'b0);

        // Interrupts; upper CON bits written must be ignored
        con_write(32'hFFFF_FFFF);
        tick(2);
        rd_con_chk("con_en", 1'b0);
        chk("irq_idle", {31'h0, irq}, 32'h0);
        send_rx($urandom_range(0, 255), 1'b1);
        chk("irq_rx", {31'h0, irq}, 32'h1);
        rd_rxd_chk("irq_rxd");
        chk("irq_hold", {31'h0, irq}, 32'h1);
        tick(1);
        chk("irq_drop", {31'h0, irq}, 32'h0);

        // TXD write while busy must not alter the frame
        tx_frame($urandom_range(0, 255), 1'b1);

        // Reset in the middle of a frame
        send_rx($urandom_range(0, 255), 1'b1);
        chk("irq_pre_rst", {31'h0, irq}, {31'h0, exp_irq()});
        b  = $urandom_range(0, 255);
        fr = {1'b1, b, 1'b0};
        bus_write(A_TXD, {24'h0, b});
        tick(4 * DIV + DIV / 2);
        chk("midtx_bit4", {31'h0, tx}, {31'h0, fr[4]});
        do_reset();
        chk("midrst_tx", {31'h0, tx}, 32'h1);
        chk("midrst_irq", {31'h0, irq}, 32'h0);
        rd_con_chk("midrst_con", 1'b0);
        rd_rxd_chk("midrst_rxd");
        tx_frame($urandom_range(0, 255), 1'b0);

        // Randomized mix of enables, frames and reads
        for (int i = 0; i < 10; i++) begin
            con_write($urandom);
            kind = $urandom_range(0, 4);
            case (kind)
                0: glitch_rx();
                1: begin send_rx($urandom_range(0, 255), 1'b0); tick(DIV); end
                4: tx_frame($urandom_range(0, 255), 1'b0);
                default: send_rx($urandom_range(0, 255), 1'b1);
            endcase
            tick(2);
            chk($sformatf("rand_irq%0d", i), {31'h0, irq}, {31'h0, exp_irq()});
            case ($urandom_range(0, 2))
                0: rd_rxd_chk($sformatf("rand_rxd%0d", i));
                1: rd_con_chk($sformatf("rand_con%0d", i), 1'b0);
                default: tick(1);
            endcase
        end
        tick(2);
        rd_con_chk("final_con", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
